// File: rtl/tx_symbol_framer.sv
// QPSK transmit framer: wraps a payload byte stream in preamble, sync word and
// a zero tail, and emits it two bits (I,Q) per symbol under a valid/ready handshake.
module tx_symbol_framer #(
    parameter int unsigned PREAMBLE_BYTES   = 4,
    parameter logic [7:0]  PREAMBLE_PATTERN = 8'hAA,
    parameter logic [15:0] SYNC_WORD        = 16'h2DD4,
    parameter int unsigned TAIL_SYMBOLS     = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] in_data,
    input  logic       in_valid,
    input  logic       in_last,
    output logic       in_ready,
    output logic       out_I,
    output logic       out_Q,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       busy,
    output logic       underrun
);

    // state    | meaning
    // IDLE     | no frame; waits for in_valid to start one
    // PREAMBLE | sending PREAMBLE_BYTES copies of the pattern byte
    // SYNC     | sending the sync word, high byte then low byte
    // PAYLOAD  | streaming accepted payload bytes
    // TAIL     | sending TAIL_SYMBOLS zero dibits
    typedef enum logic [2:0] {IDLE, PREAMBLE, SYNC, PAYLOAD, TAIL} state_t;

    localparam logic [7:0] PRE_LOAD  = 8'(PREAMBLE_BYTES - 1);
    localparam logic [3:0] TAIL_LOAD = 4'(TAIL_SYMBOLS - 1);

    state_t     state;
    logic [7:0] sr;
    logic [1:0] dcnt;
    logic       sv;
    logic [7:0] pcnt;
    logic [3:0] tcnt;
    logic       sync_lo;
    logic       last_pend;
    logic       underrun_r;

    logic xfer;
    logic byte_done;
    logic accept;

    assign xfer      = sv & out_ready;
    assign byte_done = xfer & (dcnt == 2'd3);
    // Once the last byte is held, the next upstream byte belongs to the next frame.
    assign in_ready  = (state == PAYLOAD) & ~last_pend & (~sv | (out_ready & (dcnt == 2'd3)));
    assign accept    = in_ready & in_valid;

    assign out_I     = sr[7];
    assign out_Q     = sr[6];
    assign out_valid = sv;
    assign busy      = (state != IDLE);
    assign underrun  = underrun_r;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            sr         <= '0;
            dcnt       <= '0;
            sv         <= 1'b0;
            pcnt       <= '0;
            tcnt       <= '0;
            sync_lo    <= 1'b0;
            last_pend  <= 1'b0;
            underrun_r <= 1'b0;
        end else begin
            underrun_r <= 1'b0;
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        state <= PREAMBLE;
                        sr    <= PREAMBLE_PATTERN;
                        dcnt  <= '0;
                        sv    <= 1'b1;
                        pcnt  <= PRE_LOAD;
                    end
                end
                PREAMBLE: begin
                    if (xfer) begin
                        sr   <= {sr[5:0], 2'b00};
                        dcnt <= dcnt + 2'd1;
                    end
                    if (byte_done) begin
                        if (pcnt == 8'd0) begin
                            state   <= SYNC;
                            sr      <= SYNC_WORD[15:8];
                            sync_lo <= 1'b0;
                        end else begin
                            sr   <= PREAMBLE_PATTERN;
                            pcnt <= pcnt - 8'd1;
                        end
                    end
                end
                SYNC: begin
                    if (xfer) begin
                        sr   <= {sr[5:0], 2'b00};
                        dcnt <= dcnt + 2'd1;
                    end
                    if (byte_done) begin
                        if (!sync_lo) begin
                            sr      <= SYNC_WORD[7:0];
                            sync_lo <= 1'b1;
                        end else begin
                            state <= PAYLOAD;
                            sv    <= 1'b0;
                        end
                    end
                end
                PAYLOAD: begin
                    if (xfer) begin
                        sr   <= {sr[5:0], 2'b00};
                        dcnt <= dcnt + 2'd1;
                    end
                    if (byte_done) begin
                        if (last_pend) begin
                            state     <= TAIL;
                            sr        <= '0;
                            dcnt      <= '0;
                            tcnt      <= TAIL_LOAD;
                            last_pend <= 1'b0;
                        end else if (!in_valid) begin
                            sv         <= 1'b0;
                            underrun_r <= 1'b1;
                        end
                    end
                    if (accept) begin
                        sr        <= in_data;
                        dcnt      <= '0;
                        sv        <= 1'b1;
                        last_pend <= in_last;
                    end
                end
                TAIL: begin
                    if (xfer) begin
                        dcnt <= dcnt + 2'd1;
                        if (tcnt == 4'd0) begin
                            state <= IDLE;
                            sv    <= 1'b0;
                        end else begin
                            tcnt <= tcnt - 4'd1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    sv    <= 1'b0;
                end
            endcase
        end
    end

endmodule
